// File: rtl/router_sync.sv
// Router synchronizer: latches the packet destination, steers FIFO writes and full/valid flags,
// and (with ROUTER_SYNC_TIMEOUT_EN defined) issues per-port soft resets on read stalls.
module router_sync #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       detect_add,
    input  logic [1:0] datain,
    input  logic       write_enb_reg,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    logic [1:0] addr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= 2'b00;
        end else if (detect_add) begin
            addr_q <= datain;
        end
    end

    // Address 11 is an invalid destination: no write, and never reports full.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

`ifdef ROUTER_SYNC_TIMEOUT_EN
    localparam logic [4:0] TERM_CNT = 5'(TIMEOUT - 1);

    logic [2:0] vld_v;
    logic [2:0] rd_v;
    logic [2:0] sr_v;

    assign vld_v = {vld_out_2, vld_out_1, vld_out_0};
    assign rd_v  = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar g = 0; g < 3; g++) begin : g_port
        logic [4:0] cnt_q;
        logic [4:0] cnt_d;
        logic       sr_q;
        logic       sr_d;

        // Counter holds when the port is idle (no data, no read); any read activity clears it.
        always_comb begin
            cnt_d = cnt_q;
            sr_d  = 1'b0;
            if (vld_v[g] && !rd_v[g]) begin
                if (cnt_q == TERM_CNT) begin
                    cnt_d = 5'd0;
                    sr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end else if (vld_v[g] || rd_v[g]) begin
                cnt_d = 5'd0;
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q <= 5'd0;
                sr_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sr_q  <= sr_d;
            end
        end

        assign sr_v[g] = sr_q;
    end

    assign soft_reset_0 = sr_v[0];
    assign soft_reset_1 = sr_v[1];
    assign soft_reset_2 = sr_v[2];
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_rd;
    assign unused_rd = ^{read_enb_0, read_enb_1, read_enb_2, unused_timeout[0]};

    assign soft_reset_0 = 1'b0;
    assign soft_reset_1 = 1'b0;
    assign soft_reset_2 = 1'b0;
`endif

endmodule

// File: tb/tb_router_sync.sv
// Directed self-checking bench for router_sync; timeout expectations follow ROUTER_SYNC_TIMEOUT_EN.
module tb_router_sync;

    localparam int TO = 30;
`ifdef ROUTER_SYNC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       detect_add = 1'b0;
    logic [1:0] datain = 2'b00;
    logic       write_enb_reg = 1'b0;
    logic       full_0 = 1'b0, full_1 = 1'b0, full_2 = 1'b0;
    logic       empty_0 = 1'b1, empty_1 = 1'b1, empty_2 = 1'b1;
    logic       read_enb_0 = 1'b0, read_enb_1 = 1'b0, read_enb_2 = 1'b0;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int checks = 0;
    int failures = 0;

    router_sync #(.TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .detect_add(detect_add), .datain(datain),
        .write_enb_reg(write_enb_reg),
        .full_0(full_0), .full_1(full_1), .full_2(full_2),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic latch_addr(input logic [1:0] a);
        detect_add = 1'b1;
        datain = a;
        tick();
        detect_add = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        write_enb_reg = 1'b1;
        full_0 = 1'b1; full_1 = 1'b0; full_2 = 1'b0;
        empty_0 = 1'b0; empty_1 = 1'b1; empty_2 = 1'b0;
        tick();
        #1;
        checks++;
        if (write_enb !== 3'b001) begin
            failures++;
            $display("FAIL reset_write_enb got=%b exp=001", write_enb);
        end
        checks++;
        if (fifo_full !== 1'b1) begin
            failures++;
            $display("FAIL reset_fifo_full got=%b exp=1", fifo_full);
        end
        checks++;
        if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b101) begin
            failures++;
            $display("FAIL reset_vld got=%b exp=101", {vld_out_2, vld_out_1, vld_out_0});
        end
        checks++;
        if ({soft_reset_2, soft_reset_1, soft_reset_0} !== 3'b000) begin
            failures++;
            $display("FAIL reset_soft_reset got=%b exp=000", {soft_reset_2, soft_reset_1, soft_reset_0});
        end
        empty_0 = 1'b1; empty_2 = 1'b1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_route();
        logic [2:0] exp_we [4];
        logic       exp_ff [4];
        exp_we[0] = 3'b001; exp_we[1] = 3'b010; exp_we[2] = 3'b100; exp_we[3] = 3'b000;
        full_0 = 1'b0; full_1 = 1'b1; full_2 = 1'b1;
        exp_ff[0] = 1'b0; exp_ff[1] = 1'b1; exp_ff[2] = 1'b1; exp_ff[3] = 1'b0;
        for (int a = 0; a < 4; a++) begin
            write_enb_reg = 1'b1;
            latch_addr(2'(a));
            checks++;
            if (write_enb !== exp_we[a]) begin
                failures++;
                $display("FAIL route_we addr=%0d got=%b exp=%b", a, write_enb, exp_we[a]);
            end
            checks++;
            if (fifo_full !== exp_ff[a]) begin
                failures++;
                $display("FAIL route_full addr=%0d got=%b exp=%b", a, fifo_full, exp_ff[a]);
            end
            write_enb_reg = 1'b0;
            #1;
            checks++;
            if (write_enb !== 3'b000) begin
                failures++;
                $display("FAIL route_we_idle addr=%0d got=%b exp=000", a, write_enb);
            end
        end
        full_0 = 1'b1; full_1 = 1'b1; full_2 = 1'b1;
        write_enb_reg = 1'b1;
        latch_addr(2'b11);
        checks++;
        if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
            failures++;
            $display("FAIL route_invalid got we=%b ff=%b exp we=000 ff=0", write_enb, fifo_full);
        end
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;
    endtask

    task automatic test_latency();
        write_enb_reg = 1'b1;
        latch_addr(2'b01);
        detect_add = 1'b1;
        datain = 2'b10;
        #1;
        checks++;
        if (write_enb !== 3'b010) begin
            failures++;
            $display("FAIL latency_before got=%b exp=010", write_enb);
        end
        tick();
        detect_add = 1'b0;
        datain = 2'b00;
        checks++;
        if (write_enb !== 3'b100) begin
            failures++;
            $display("FAIL latency_after got=%b exp=100", write_enb);
        end
        tick();
        checks++;
        if (write_enb !== 3'b100) begin
            failures++;
            $display("FAIL latency_hold got=%b exp=100", write_enb);
        end
    endtask

    task automatic test_vld();
        logic [2:0] pats [4];
        pats[0] = 3'b000; pats[1] = 3'b101; pats[2] = 3'b010; pats[3] = 3'b111;
        for (int i = 0; i < 4; i++) begin
            {empty_2, empty_1, empty_0} = pats[i];
            #1;
            checks++;
            if ({vld_out_2, vld_out_1, vld_out_0} !== ~pats[i]) begin
                failures++;
                $display("FAIL vld pat=%0d got=%b exp=%b", i, {vld_out_2, vld_out_1, vld_out_0}, ~pats[i]);
            end
        end
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
    endtask

    task automatic test_timeout_repeat();
        int bad = 0;
        do_reset();
        write_enb_reg = 1'b1;
        full_0 = 1'b0; full_1 = 1'b1; full_2 = 1'b1;
        latch_addr(2'b10);
        checks++;
        if (write_enb !== 3'b100 || fifo_full !== 1'b1) begin
            failures++;
            $display("FAIL scen_route got we=%b ff=%b exp we=100 ff=1", write_enb, fifo_full);
        end
        do_reset();
        latch_addr(2'b10);
        // Port 0 idle, port 1 drained every cycle, port 2 stalled.
        empty_0 = 1'b1; empty_1 = 1'b0; empty_2 = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b1; read_enb_2 = 1'b0;
        #1;
        checks++;
        if ({vld_out_2, vld_out_1, vld_out_0} !== 3'b110) begin
            failures++;
            $display("FAIL scen_vld got=%b exp=110", {vld_out_2, vld_out_1, vld_out_0});
        end
        for (int i = 1; i <= 2 * TO + 5; i++) begin
            tick();
            checks++;
            if (soft_reset_2 !== (TO_EN && (i % TO == 0))) begin
                failures++;
                $display("FAIL timeout_sr2 edge=%0d got=%b exp=%b", i, soft_reset_2, TO_EN && (i % TO == 0));
            end
            if (soft_reset_1 !== 1'b0 || soft_reset_0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_quiet_ports got=%0d bad edges exp=0", bad);
        end
        empty_1 = 1'b1; empty_2 = 1'b1; read_enb_1 = 1'b0;
    endtask

    task automatic test_read_clear();
        int early = 0;
        do_reset();
        empty_0 = 1'b0;
        read_enb_0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (soft_reset_0 !== 1'b0) early++;
        end
        read_enb_0 = 1'b1;
        tick();
        if (soft_reset_0 !== 1'b0) early++;
        read_enb_0 = 1'b0;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (soft_reset_0 !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL read_clear_early got=%0d pulses exp=0", early);
        end
        tick();
        checks++;
        if (soft_reset_0 !== TO_EN) begin
            failures++;
            $display("FAIL read_clear_pulse got=%b exp=%b", soft_reset_0, TO_EN);
        end
        tick();
        checks++;
        if (soft_reset_0 !== 1'b0) begin
            failures++;
            $display("FAIL read_clear_width got=%b exp=0", soft_reset_0);
        end
        empty_0 = 1'b1;
    endtask

    task automatic test_reset_mid();
        int early = 0;
        do_reset();
        write_enb_reg = 1'b1;
        latch_addr(2'b10);
        empty_2 = 1'b0;
        read_enb_2 = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (soft_reset_2 !== 1'b0 || write_enb !== 3'b001) begin
            failures++;
            $display("FAIL reset_mid_async got sr2=%b we=%b exp sr2=0 we=001", soft_reset_2, write_enb);
        end
        tick();
        resetn = 1'b1;
        for (int i = 1; i < TO; i++) begin
            tick();
            if (soft_reset_2 !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL reset_mid_early got=%0d pulses exp=0", early);
        end
        tick();
        checks++;
        if (soft_reset_2 !== TO_EN) begin
            failures++;
            $display("FAIL reset_mid_pulse got=%b exp=%b", soft_reset_2, TO_EN);
        end
        // Reset landing on an active pulse must drop it without waiting for a clock edge.
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (soft_reset_2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse_clear got=%b exp=0", soft_reset_2);
        end
        tick();
        resetn = 1'b1;
        empty_2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_route();
        test_latency();
        test_vld();
        test_timeout_repeat();
        test_read_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
